// File: rtl/id_ex_pipe_stage.sv
// id_ex_pipe_stage: decode-to-execute pipeline register.
// Holds the decoded control, data and register-address fields for the
// execute stage, with a valid bit, stall (hold), flush (bubble) and a
// synchronous active-high reset. Priority on each edge: rst > flush > stall > load.
// Optional build macro: PIPE_PERF_CNT_EN adds saturating stall/bubble counters;
// without it both counter outputs are tied to zero.

module id_ex_pipe_stage #(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int ALU_CTRL_WIDTH = 4,
    parameter int CNT_WIDTH      = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      stallE_i,
    input  logic                      flushE_i,
    input  logic                      validD_i,
    input  logic                      regWriteD_i,
    input  logic [1:0]                resultSrcD_i,
    input  logic                      memWriteD_i,
    input  logic                      branchD_i,
    input  logic                      jumpD_i,
    input  logic                      jalrD_i,
    input  logic                      ALUSrcD_i,
    input  logic [ALU_CTRL_WIDTH-1:0] ALUCtrlD_i,
    input  logic [DATA_WIDTH-1:0]     PCD_i,
    input  logic [DATA_WIDTH-1:0]     RD1D_i,
    input  logic [DATA_WIDTH-1:0]     RD2D_i,
    input  logic [DATA_WIDTH-1:0]     ImmExtD_i,
    input  logic [REG_ADDR_WIDTH-1:0] rs1D_i,
    input  logic [REG_ADDR_WIDTH-1:0] rs2D_i,
    input  logic [REG_ADDR_WIDTH-1:0] rdD_i,
    output logic                      validE_o,
    output logic                      regWriteE_o,
    output logic [1:0]                resultSrcE_o,
    output logic                      memWriteE_o,
    output logic                      branchE_o,
    output logic                      jumpE_o,
    output logic                      jalrE_o,
    output logic                      ALUSrcE_o,
    output logic [ALU_CTRL_WIDTH-1:0] ALUCtrlE_o,
    output logic [DATA_WIDTH-1:0]     PCE_o,
    output logic [DATA_WIDTH-1:0]     RD1E_o,
    output logic [DATA_WIDTH-1:0]     RD2E_o,
    output logic [DATA_WIDTH-1:0]     ImmExtE_o,
    output logic [REG_ADDR_WIDTH-1:0] rs1E_o,
    output logic [REG_ADDR_WIDTH-1:0] rs2E_o,
    output logic [REG_ADDR_WIDTH-1:0] rdE_o,
    output logic [CNT_WIDTH-1:0]      stallCount_o,
    output logic [CNT_WIDTH-1:0]      bubbleCount_o
);

    // Pipeline state registers and their next-state values.
    logic                      valid_q,      valid_d;
    logic                      reg_write_q,  reg_write_d;
    logic [1:0]                result_src_q, result_src_d;
    logic                      mem_write_q,  mem_write_d;
    logic                      branch_q,     branch_d;
    logic                      jump_q,       jump_d;
    logic                      jalr_q,       jalr_d;
    logic                      alu_src_q,    alu_src_d;
    logic [ALU_CTRL_WIDTH-1:0] alu_ctrl_q,   alu_ctrl_d;
    logic [DATA_WIDTH-1:0]     pc_q,         pc_d;
    logic [DATA_WIDTH-1:0]     rd1_q,        rd1_d;
    logic [DATA_WIDTH-1:0]     rd2_q,        rd2_d;
    logic [DATA_WIDTH-1:0]     imm_ext_q,    imm_ext_d;
    logic [REG_ADDR_WIDTH-1:0] rs1_q,        rs1_d;
    logic [REG_ADDR_WIDTH-1:0] rs2_q,        rs2_d;
    logic [REG_ADDR_WIDTH-1:0] rd_q,         rd_d;

    // A register write is only architecturally meaningful for a real
    // instruction that targets something other than x0.
    logic rd_nonzero;
    assign rd_nonzero = (rdD_i != '0);

    // Next-state selection: flush inserts a bubble, stall holds, otherwise load with gating.
    always_comb begin
        valid_d      = valid_q;
        reg_write_d  = reg_write_q;
        result_src_d = result_src_q;
        mem_write_d  = mem_write_q;
        branch_d     = branch_q;
        jump_d       = jump_q;
        jalr_d       = jalr_q;
        alu_src_d    = alu_src_q;
        alu_ctrl_d   = alu_ctrl_q;
        pc_d         = pc_q;
        rd1_d        = rd1_q;
        rd2_d        = rd2_q;
        imm_ext_d    = imm_ext_q;
        rs1_d        = rs1_q;
        rs2_d        = rs2_q;
        rd_d         = rd_q;

        if (flushE_i) begin
            valid_d      = 1'b0;
            reg_write_d  = 1'b0;
            result_src_d = '0;
            mem_write_d  = 1'b0;
            branch_d     = 1'b0;
            jump_d       = 1'b0;
            jalr_d       = 1'b0;
            alu_src_d    = 1'b0;
            alu_ctrl_d   = '0;
            pc_d         = '0;
            rd1_d        = '0;
            rd2_d        = '0;
            imm_ext_d    = '0;
            rs1_d        = '0;
            rs2_d        = '0;
            rd_d         = '0;
        end else if (!stallE_i) begin
            valid_d      = validD_i;
            reg_write_d  = validD_i & regWriteD_i & rd_nonzero;
            result_src_d = resultSrcD_i;
            mem_write_d  = validD_i & memWriteD_i;
            branch_d     = validD_i & branchD_i;
            jump_d       = validD_i & jumpD_i;
            jalr_d       = validD_i & jalrD_i;
            alu_src_d    = ALUSrcD_i;
            alu_ctrl_d   = ALUCtrlD_i;
            pc_d         = PCD_i;
            rd1_d        = RD1D_i;
            rd2_d        = RD2D_i;
            imm_ext_d    = ImmExtD_i;
            rs1_d        = rs1D_i;
            rs2_d        = rs2D_i;
            rd_d         = rdD_i;
        end
    end

    // Pipeline register update with synchronous reset to the all-zero state.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q      <= 1'b0;
            reg_write_q  <= 1'b0;
            result_src_q <= '0;
            mem_write_q  <= 1'b0;
            branch_q     <= 1'b0;
            jump_q       <= 1'b0;
            jalr_q       <= 1'b0;
            alu_src_q    <= 1'b0;
            alu_ctrl_q   <= '0;
            pc_q         <= '0;
            rd1_q        <= '0;
            rd2_q        <= '0;
            imm_ext_q    <= '0;
            rs1_q        <= '0;
            rs2_q        <= '0;
            rd_q         <= '0;
        end else begin
            valid_q      <= valid_d;
            reg_write_q  <= reg_write_d;
            result_src_q <= result_src_d;
            mem_write_q  <= mem_write_d;
            branch_q     <= branch_d;
            jump_q       <= jump_d;
            jalr_q       <= jalr_d;
            alu_src_q    <= alu_src_d;
            alu_ctrl_q   <= alu_ctrl_d;
            pc_q         <= pc_d;
            rd1_q        <= rd1_d;
            rd2_q        <= rd2_d;
            imm_ext_q    <= imm_ext_d;
            rs1_q        <= rs1_d;
            rs2_q        <= rs2_d;
            rd_q         <= rd_d;
        end
    end

    assign validE_o     = valid_q;
    assign regWriteE_o  = reg_write_q;
    assign resultSrcE_o = result_src_q;
    assign memWriteE_o  = mem_write_q;
    assign branchE_o    = branch_q;
    assign jumpE_o      = jump_q;
    assign jalrE_o      = jalr_q;
    assign ALUSrcE_o    = alu_src_q;
    assign ALUCtrlE_o   = alu_ctrl_q;
    assign PCE_o        = pc_q;
    assign RD1E_o       = rd1_q;
    assign RD2E_o       = rd2_q;
    assign ImmExtE_o    = imm_ext_q;
    assign rs1E_o       = rs1_q;
    assign rs2E_o       = rs2_q;
    assign rdE_o        = rd_q;

`ifdef PIPE_PERF_CNT_EN
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    logic [CNT_WIDTH-1:0] stall_count_q,  stall_count_d;
    logic [CNT_WIDTH-1:0] bubble_count_q, bubble_count_d;

    // Saturating event counters: a stall counts only when not overridden by flush.
    always_comb begin
        stall_count_d  = stall_count_q;
        bubble_count_d = bubble_count_q;
        if (flushE_i) begin
            if (bubble_count_q != CNT_MAX) begin
                bubble_count_d = bubble_count_q + CNT_ONE;
            end
        end else if (stallE_i) begin
            if (stall_count_q != CNT_MAX) begin
                stall_count_d = stall_count_q + CNT_ONE;
            end
        end
    end

    // Counter registers clear only on reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_count_q  <= '0;
            bubble_count_q <= '0;
        end else begin
            stall_count_q  <= stall_count_d;
            bubble_count_q <= bubble_count_d;
        end
    end

    assign stallCount_o  = stall_count_q;
    assign bubbleCount_o = bubble_count_q;
`else
    assign stallCount_o  = '0;
    assign bubbleCount_o = '0;
`endif

endmodule

// File: tb/tb_id_ex_pipe_stage.sv
// tb_id_ex_pipe_stage: scoreboard bench for id_ex_pipe_stage.
// A reference model computes the expected execute-stage contents for every
// edge and queues them; a monitor on the falling edge pops and compares.

module tb_id_ex_pipe_stage;

    localparam int CW = 4;

    typedef struct packed {
        logic        valid;
        logic        reg_write;
        logic [1:0]  result_src;
        logic        mem_write;
        logic        branch;
        logic        jump;
        logic        jalr;
        logic        alu_src;
        logic [3:0]  alu_ctrl;
        logic [31:0] pc;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
    } fields_t;

    typedef struct packed {
        fields_t       f;
        logic [CW-1:0] stall_cnt;
        logic [CW-1:0] bubble_cnt;
    } state_t;

    logic clk = 1'b0;
    logic rst, stall, flush;
    fields_t din;

    logic          valid_e, reg_write_e, mem_write_e, branch_e, jump_e, jalr_e, alu_src_e;
    logic [1:0]    result_src_e;
    logic [3:0]    alu_ctrl_e;
    logic [31:0]   pc_e, rd1_e, rd2_e, imm_e;
    logic [4:0]    rs1_e, rs2_e, rd_e;
    logic [CW-1:0] stall_cnt_e, bubble_cnt_e;

    state_t model;
    state_t exp_q[$];
    int check_count = 0;
    int pass_count  = 0;

    always #5 clk = ~clk;

    id_ex_pipe_stage #(
        .DATA_WIDTH(32), .REG_ADDR_WIDTH(5), .ALU_CTRL_WIDTH(4), .CNT_WIDTH(CW)
    ) dut (
        .clk(clk), .rst(rst), .stallE_i(stall), .flushE_i(flush),
        .validD_i(din.valid), .regWriteD_i(din.reg_write), .resultSrcD_i(din.result_src),
        .memWriteD_i(din.mem_write), .branchD_i(din.branch), .jumpD_i(din.jump),
        .jalrD_i(din.jalr), .ALUSrcD_i(din.alu_src), .ALUCtrlD_i(din.alu_ctrl),
        .PCD_i(din.pc), .RD1D_i(din.rd1), .RD2D_i(din.rd2), .ImmExtD_i(din.imm),
        .rs1D_i(din.rs1), .rs2D_i(din.rs2), .rdD_i(din.rd),
        .validE_o(valid_e), .regWriteE_o(reg_write_e), .resultSrcE_o(result_src_e),
        .memWriteE_o(mem_write_e), .branchE_o(branch_e), .jumpE_o(jump_e),
        .jalrE_o(jalr_e), .ALUSrcE_o(alu_src_e), .ALUCtrlE_o(alu_ctrl_e),
        .PCE_o(pc_e), .RD1E_o(rd1_e), .RD2E_o(rd2_e), .ImmExtE_o(imm_e),
        .rs1E_o(rs1_e), .rs2E_o(rs2_e), .rdE_o(rd_e),
        .stallCount_o(stall_cnt_e), .bubbleCount_o(bubble_cnt_e)
    );

    // Reference behaviour of one clock edge, written from the stage's rules.
    function automatic state_t next_state(state_t cur, logic r, logic f, logic s, fields_t d);
        state_t n;
        int sc, bc, top;
        n   = cur;
        top = (1 << CW) - 1;
        sc  = int'(cur.stall_cnt);
        bc  = int'(cur.bubble_cnt);
        if (r) begin
            n = '0;
        end else if (f) begin
            n.f = '0;
`ifdef PIPE_PERF_CNT_EN
            if (bc < top) bc = bc + 1;
            n.bubble_cnt = CW'(bc);
`endif
        end else if (s) begin
`ifdef PIPE_PERF_CNT_EN
            if (sc < top) sc = sc + 1;
            n.stall_cnt = CW'(sc);
`endif
        end else begin
            n.f = d;
            if (!d.valid) begin
                n.f.reg_write = 1'b0;
                n.f.mem_write = 1'b0;
                n.f.branch    = 1'b0;
                n.f.jump      = 1'b0;
                n.f.jalr      = 1'b0;
            end
            if (d.rd == 5'd0) n.f.reg_write = 1'b0;
        end
        return n;
    endfunction

    // Drive one cycle of inputs, queue the expected post-edge state, advance past the edge.
    task automatic apply_stimulus(input logic r, input logic f, input logic s, input fields_t d);
        rst   = r;
        flush = f;
        stall = s;
        din   = d;
        model = next_state(model, r, f, s, d);
        exp_q.push_back(model);
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        check_count++;
        if (act === exp) pass_count++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    function automatic fields_t rand_fields();
        fields_t d;
        d.valid      = ($urandom_range(0, 3) != 0);
        d.reg_write  = 1'($urandom);
        d.result_src = 2'($urandom_range(0, 2));
        d.mem_write  = 1'($urandom);
        d.branch     = 1'($urandom);
        d.jump       = 1'($urandom);
        d.jalr       = 1'($urandom);
        d.alu_src    = 1'($urandom);
        d.alu_ctrl   = 4'($urandom);
        d.pc         = $urandom;
        d.rd1        = $urandom;
        d.rd2        = $urandom;
        d.imm        = $urandom;
        d.rs1        = 5'($urandom);
        d.rs2        = 5'($urandom);
        d.rd         = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
        return d;
    endfunction

    // Monitor: after each rising edge, compare DUT outputs against the oldest expectation.
    initial begin
        state_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check_output("validE",     32'(valid_e),      32'(e.f.valid));
                check_output("regWriteE",  32'(reg_write_e),  32'(e.f.reg_write));
                check_output("resultSrcE", 32'(result_src_e), 32'(e.f.result_src));
                check_output("memWriteE",  32'(mem_write_e),  32'(e.f.mem_write));
                check_output("branchE",    32'(branch_e),     32'(e.f.branch));
                check_output("jumpE",      32'(jump_e),       32'(e.f.jump));
                check_output("jalrE",      32'(jalr_e),       32'(e.f.jalr));
                check_output("ALUSrcE",    32'(alu_src_e),    32'(e.f.alu_src));
                check_output("ALUCtrlE",   32'(alu_ctrl_e),   32'(e.f.alu_ctrl));
                check_output("PCE",        pc_e,              e.f.pc);
                check_output("RD1E",       rd1_e,             e.f.rd1);
                check_output("RD2E",       rd2_e,             e.f.rd2);
                check_output("ImmExtE",    imm_e,             e.f.imm);
                check_output("rs1E",       32'(rs1_e),        32'(e.f.rs1));
                check_output("rs2E",       32'(rs2_e),        32'(e.f.rs2));
                check_output("rdE",        32'(rd_e),         32'(e.f.rd));
                check_output("stallCount", 32'(stall_cnt_e),  32'(e.stall_cnt));
                check_output("bubbleCount",32'(bubble_cnt_e), 32'(e.bubble_cnt));
            end
        end
    end

    // Directed scenarios followed by randomized traffic.
    initial begin
        fields_t d;
        model = '0;
        rst = 1'b1; flush = 1'b0; stall = 1'b0; din = '0;

        // Reset with busy inputs
        d = rand_fields();
        d.valid = 1'b1; d.pc = 32'h100; d.rd = 5'd5; d.reg_write = 1'b1;
        apply_stimulus(1'b1, 1'b0, 1'b0, d);
        apply_stimulus(1'b1, 1'b0, 1'b0, d);

        // Plain load
        d = '0;
        d.valid = 1'b1; d.pc = 32'h40; d.rd1 = 32'hDEAD_BEEF; d.rd = 5'd7;
        d.reg_write = 1'b1; d.alu_ctrl = 4'b0010;
        apply_stimulus(1'b0, 1'b0, 1'b0, d);

        // Stall hold for three edges, then release
        d.pc = 32'h44;
        apply_stimulus(1'b0, 1'b0, 1'b0, d);
        d.pc = 32'h48;
        repeat (3) apply_stimulus(1'b0, 1'b0, 1'b1, d);
        apply_stimulus(1'b0, 1'b0, 1'b0, d);

        // Flush overriding stall
        d.mem_write = 1'b1;
        apply_stimulus(1'b0, 1'b1, 1'b1, d);

        // Gating by valid and by destination
        d = rand_fields();
        d.valid = 1'b0; d.mem_write = 1'b1; d.branch = 1'b1;
        apply_stimulus(1'b0, 1'b0, 1'b0, d);
        d = rand_fields();
        d.valid = 1'b1; d.rd = 5'd0; d.reg_write = 1'b1;
        apply_stimulus(1'b0, 1'b0, 1'b0, d);

        // Saturation, then reset mid-stall and mid-flush
        repeat (20) apply_stimulus(1'b0, 1'b0, 1'b1, rand_fields());
        apply_stimulus(1'b1, 1'b0, 1'b1, rand_fields());
        repeat (20) apply_stimulus(1'b0, 1'b1, 1'b0, rand_fields());
        apply_stimulus(1'b1, 1'b1, 1'b0, rand_fields());

        // Randomized traffic
        for (int i = 0; i < 2000; i++) begin
            apply_stimulus(($urandom_range(0, 63) == 0),
                           ($urandom_range(0, 9) == 0),
                           ($urandom_range(0, 3) == 0),
                           rand_fields());
        end

        repeat (2) @(negedge clk);
        check_output("drain", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule

// File: doc/id_ex_pipe_stage.md
Name: id_ex_pipe_stage

Overview:
Parametrised decode-to-execute pipeline register, successor to the fixed-width D/E latch. Adds a valid bit, stall (hold), flush (bubble insert) and synchronous reset. Carries register addresses forward so the hazard/forwarding unit can compare them in execute. Sits between the decode stage and the ALU/branch logic; the hazard unit drives stall and flush.

Parameters:
DATA_WIDTH, 32, width of PC, operand and immediate fields
REG_ADDR_WIDTH, 5, width of the rs1/rs2/rd register-file address fields
ALU_CTRL_WIDTH, 4, width of the ALU control field
CNT_WIDTH, 16, width of the performance counters (only used with PIPE_PERF_CNT_EN)

Ports:
clk  in  1  clock, all state updates on the rising edge
rst  in  1  synchronous reset, active-high
stallE_i  in  1  hold all execute-stage outputs
flushE_i  in  1  replace the next execute-stage contents with a bubble
validD_i  in  1  decode stage holds a real instruction
regWriteD_i  in  1  instruction writes the register file
resultSrcD_i  in  2  result mux select: 0 = ALU, 1 = memory, 2 = PC+4
memWriteD_i  in  1  store enable
branchD_i  in  1  conditional branch
jumpD_i  in  1  JAL
jalrD_i  in  1  JALR
ALUSrcD_i  in  1  ALU B operand select: 0 = register, 1 = immediate
ALUCtrlD_i  in  ALU_CTRL_WIDTH  ALU operation
PCD_i  in  DATA_WIDTH  PC of the instruction
RD1D_i, RD2D_i  in  DATA_WIDTH each  register-file read data
ImmExtD_i  in  DATA_WIDTH  sign-extended immediate
rs1D_i, rs2D_i, rdD_i  in  REG_ADDR_WIDTH each  source and destination addresses
validE_o, regWriteE_o, resultSrcE_o, memWriteE_o, branchE_o, jumpE_o, jalrE_o, ALUSrcE_o, ALUCtrlE_o, PCE_o, RD1E_o, RD2E_o, ImmExtE_o, rs1E_o, rs2E_o, rdE_o  out  same widths as the matching inputs  registered execute-stage copies
stallCount_o  out  CNT_WIDTH  cycles held by stall (only with PIPE_PERF_CNT_EN)
bubbleCount_o  out  CNT_WIDTH  bubbles inserted by flush (only with PIPE_PERF_CNT_EN)

Behaviour:
- Each rising edge resolves exactly one action. Priority is rst > flushE_i > stallE_i > load.
- rst: every output goes to 0, including validE_o, all data/address fields and both counters.
- flushE_i = 1: the same all-zero state as reset, except the counters. Zero control means no register write, no store, no branch, no jump, rdE_o = x0, so the bubble has no architectural side effect.
- flushE_i overrides stallE_i when both are 1: a bubble is inserted and the held contents are discarded.
- stallE_i = 1 with flushE_i = 0: every output keeps its value for an unbounded number of cycles.
- Load (no rst, flush or stall): every E output takes its D input on the next edge. Latency is exactly 1 cycle.
- Gating by valid:
  - If validD_i = 0 on a load, regWriteE_o, memWriteE_o, branchE_o, jumpE_o and jalrE_o load 0 regardless of their D inputs.
  - Data fields load normally; validE_o loads 0.
- Gating by destination: if rdD_i = 0, regWriteE_o loads 0 (writes to x0 are suppressed here so forwarding never matches x0).
- No combinational path from any input to any output.
- Reset asserted mid-stall or mid-flush still yields the all-zero state on the next edge.

Optional Feature:
PIPE_PERF_CNT_EN
- Defined:
  - stallCount_o increments on each edge where stallE_i = 1 and neither rst nor flushE_i is active.
  - bubbleCount_o increments on each edge where flushE_i = 1 and rst = 0.
  - Both saturate at all-ones (no wrap) and clear only on rst.
- Undefined: neither counter register exists and both outputs are tied to 0. The ports remain, so the interface is identical either way.

Test Plan:
- Reset: rst = 1 for 2 cycles with all D inputs at nonzero values (PCD_i = 0x100, rdD_i = 5, regWriteD_i = 1) -> every E output is 0 on the edge after rst is first sampled.
- Load: validD_i = 1, PCD_i = 0x0000_0040, RD1D_i = 0xDEAD_BEEF, rdD_i = 7, regWriteD_i = 1, ALUCtrlD_i = 4'b0010 -> the same values appear on the E outputs exactly one edge later.
- Stall hold: load PCD_i = 0x44, then hold stallE_i = 1 for 3 edges while PCD_i changes to 0x48 -> PCE_o stays 0x44 for all 3 cycles and becomes 0x48 on the first edge after stall drops. With the feature on, stallCount_o = 3.
- Flush over stall: stallE_i = 1 and flushE_i = 1 together with memWriteD_i = 1 -> validE_o = 0, memWriteE_o = 0, rdE_o = 0. With the feature on, bubbleCount_o increments by 1 and stallCount_o does not change.
- Gating: a load with validD_i = 0, memWriteD_i = 1, branchD_i = 1 -> memWriteE_o = 0 and branchE_o = 0. A load with validD_i = 1, rdD_i = 0, regWriteD_i = 1 -> regWriteE_o = 0 and validE_o = 1.
- Saturation (feature on, CNT_WIDTH = 4): 20 consecutive stall edges -> stallCount_o stops at 4'hF. A following rst returns it to 0.
